comparator_bist: RTL
====================

# comparator_bist

Self-checking stimulus/response engine for the equality comparator. It drives every operand pair onto the comparator's `a`/`b` inputs, samples the comparator's single-bit `c` result, and checks it against the expected `a == b`. It counts mismatches and records the first failing pair. It sits on the driving side of the comparator interface, so a comparator instance can be checked in hardware without a simulation bench.

## Interface
- `WIDTH`, default 2: operand width; vector space is 2^(2·WIDTH) pairs.
- `SETTLE`, default 1: cycles each pair is held before sampling; legal range ≥ 1.

- `clk` input, 1: single clock, all state on rising edge.
- `rst` input, 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `start` input, 1: run request; sampled only in IDLE or DONE.
- `a_out` output, WIDTH: operand A to comparator `a`.
- `b_out` output, WIDTH: operand B to comparator `b`.
- `eq_in` input, 1: comparator result `c` (1 = equal).
- `busy` output, 1: high from the start edge until DONE is entered.
- `done` output, 1: level; high in DONE until the next accepted start or reset.
- `pass` output, 1: high in DONE when `err_count == 0`; 0 elsewhere.
- `err_count` output, 2·WIDTH+1: number of mismatching pairs.
- `fail_valid` output, 1: a mismatch has been captured in this run.
- `fail_a`, `fail_b` output, WIDTH each: operands of the first mismatch.

## Operation
- Vector index `idx` is 2·WIDTH bits wide. `a_out = idx[2W-1:W]` and `b_out = idx[W-1:0]`, both driven straight from registers.
- States:
  - IDLE: all outputs at reset values.
  - SETTLE: `a_out`/`b_out` stable; a settle counter counts SETTLE cycles.
  - CHECK: one cycle; `eq_in` is sampled on the CHECK→next edge.
  - DONE.
- IDLE/DONE with `start`=1 → SETTLE. On that edge: `idx`=0, settle counter=0, `err_count`=0, `fail_valid`=0, `fail_a`/`fail_b`=0, `done`=0, `busy`=1.
- SETTLE: the counter increments each cycle. When counter = SETTLE−1 → CHECK.
- CHECK: expected = (`a_out == b_out`).
  - If `eq_in` ≠ expected: `err_count`+1. If `fail_valid`=0, also capture `fail_a`/`fail_b` and set `fail_valid`=1.
  - If `idx` = all ones → DONE (`busy`=0, `done`=1).
  - Otherwise `idx`+1, counter=0 → SETTLE.
- `err_count` cannot saturate: its maximum is 2^(2W), which fits in 2W+1 bits.
- `start` in SETTLE/CHECK is ignored. There is no abort other than `rst`.
- `start` held high in DONE restarts immediately. All results are cleared on the restart edge.
- `rst` asserted at any time: all registers return to reset values immediately (asynchronous). The FSM resumes in IDLE after deassertion. The interrupted run is lost.
- Reset values: `a_out`=0, `b_out`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_valid`=0, `fail_a`=0, `fail_b`=0; state IDLE.

## Timing
- Each pair occupies SETTLE+1 cycles: SETTLE cycles in SETTLE plus 1 in CHECK.
- `eq_in` is sampled SETTLE+1 edges after the pair is driven. The comparator path must settle within SETTLE cycles.
- Total run time is 2^(2W)·(SETTLE+1) cycles from the start edge to `done` high. For the defaults this is 32 cycles.
- `pass` and `done` rise on the same edge. Results stay stable while `done`=1.
- `busy` and `done` are never high together.
- `eq_in` is treated as synchronous to `clk`. No synchronizer is included.

## Structure
- Package `comparator_bist_pkg`:
  - `state_t` enum: IDLE, SETTLE, CHECK, DONE.
  - Default parameter constants.
- One sub-module, `bist_vec_counter`: the `idx` counter with a clear/increment/terminal-count flag. The FSM, settle counter and result registers stay in the top.

## Test plan
- Correct comparator model (`eq_in = a_out == b_out`), WIDTH=2, SETTLE=1, start pulse → `done` exactly 32 cycles later, `err_count`=0, `pass`=1, `fail_valid`=0.
- `eq_in` stuck at 0 → `err_count`=4, `pass`=0, `fail_a`=0, `fail_b`=0, `fail_valid`=1.
- `eq_in` stuck at 1 → `err_count`=12, first fail `fail_a`=0, `fail_b`=1.
- `eq_in` inverted, SETTLE=3 → `err_count`=16, `done` 64 cycles after start.
- `start` re-pulsed at cycle 5 → ignored, `done` still at cycle 32. Run repeated from DONE → results cleared on the start edge and recomputed.
- `rst` asserted mid-run at cycle 10 → all outputs 0 immediately, state IDLE. A fresh start then completes normally with `err_count`=0.

Source files
------------

// File: rtl/comparator_bist_pkg.sv
// Shared types and default parameters for the equality-comparator BIST engine.
package comparator_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam int DEF_WIDTH  = 2;
  localparam int DEF_SETTLE = 1;

endpackage

// File: rtl/bist_vec_counter.sv
// Vector index counter for the BIST engine: synchronous clear, increment, terminal-count flag.
module bist_vec_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] idx,
  output logic         last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx + W'(1);
    end
  end

  assign last = &idx;

endmodule

// File: rtl/comparator_bist.sv
// Stimulus/response engine that sweeps every operand pair through an equality comparator
// and records the mismatch count and the first failing pair.
module comparator_bist
  import comparator_bist_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  input  logic               eq_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic               fail_valid,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b
);

  localparam int IDX_W = 2 * WIDTH;
  localparam int ERR_W = 2 * WIDTH + 1;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

  state_t             state, state_nxt;
  logic               run_start;
  logic               check_now;
  logic               last;
  logic               mismatch;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;

  bist_vec_counter #(
    .W(IDX_W)
  ) u_idx (
    .clk  (clk),
    .rst  (rst),
    .clr  (run_start),
    .inc  (check_now & ~last),
    .idx  (idx),
    .last (last)
  );

  // Operands come straight from the index register so the comparator sees glitch-free inputs.
  assign a_out = idx[IDX_W-1:WIDTH];
  assign b_out = idx[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    run_start = 1'b0;
    check_now = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = ST_SETTLE;
          run_start = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        check_now = 1'b1;
        state_nxt = last ? ST_DONE : ST_SETTLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign mismatch = check_now & (eq_in != (a_out == b_out));

  // Settle counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
    end else if (run_start) begin
      cnt        <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
    end else begin
      if (check_now) begin
        cnt <= '0;
      end else if (state == ST_SETTLE) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (check_now && last) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
      if (mismatch) begin
        err_count <= err_count + ERR_W'(1);
        if (!fail_valid) begin
          fail_valid <= 1'b1;
          fail_a     <= a_out;
          fail_b     <= b_out;
        end
      end
    end
  end

  assign pass = done & (err_count == '0);

endmodule
